// File: rtl/booth_pkg.sv
// Shared types and build-dependent constants for the sequential Booth multiplier.
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding (two bits retired per clock).
package booth_pkg;

`ifdef BOOTH_RADIX4_EN
  localparam int unsigned BOOTH_RADIX = 4;
`else
  localparam int unsigned BOOTH_RADIX = 2;
`endif

  // Multiplier bits retired per iteration.
  localparam int unsigned BOOTH_SHIFT = BOOTH_RADIX / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width after sign/zero extension; radix-4 needs an even bit count.
  function automatic int unsigned booth_ext_width(input int unsigned width);
    int unsigned w1;
    w1 = width + 1;
    if (BOOTH_RADIX == 4)
      return w1 + (w1 % 2);
    else
      return w1;
  endfunction

  function automatic int unsigned booth_iters(input int unsigned width);
    return booth_ext_width(width) / BOOTH_SHIFT;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth digit recoder: maps {Q[1], Q[0], Q_1} to a signed multiple of M in {0, +-1, +-2}.
// A radix-2 digit is fed as {Q[0], Q[0], Q_1}, which this table maps to 0/+M/-M.
module booth_recoder (
  input  logic [2:0] digit_i,
  output logic       neg_o,
  output logic       zero_o,
  output logic       two_o
);

  always_comb begin
    zero_o = (digit_i == 3'b000) || (digit_i == 3'b111);
    two_o  = (digit_i == 3'b011) || (digit_i == 3'b100);
    neg_o  = digit_i[2] && !zero_o;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed/unsigned Booth multiplier with start/busy/done handshake.
// Build option: BOOTH_RADIX4_EN selects radix-4 (fewer iterations); default is radix-2.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned WX = booth_ext_width(WIDTH);
  localparam int unsigned XE = WX - WIDTH;
  localparam int unsigned WA = WX + BOOTH_SHIFT;
  localparam int unsigned N  = booth_iters(WIDTH);
  localparam int unsigned CW = $clog2(N + 1);

  state_t               state_q, state_d;
  logic [WA-1:0]        a_q, a_d;
  logic [WX-1:0]        q_q, q_d;
  logic                 q1_q, q1_d;
  logic [WX-1:0]        m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 done_q, done_d;

  logic [2:0]           digit;
  logic                 dig_neg, dig_zero, dig_two;
  logic [WA-1:0]        m_ext, mag, addend, sum;
  logic signed [WA+WX:0] shreg;

`ifdef BOOTH_RADIX4_EN
  assign digit = {q_q[1], q_q[0], q1_q};
`else
  assign digit = {q_q[0], q_q[0], q1_q};
`endif

  booth_recoder u_recoder (
    .digit_i (digit),
    .neg_o   (dig_neg),
    .zero_o  (dig_zero),
    .two_o   (dig_two)
  );

  // One iteration: add the selected multiple to A, then shift {A,Q,Q_1} arithmetically.
  always_comb begin
    m_ext  = {{BOOTH_SHIFT{m_q[WX-1]}}, m_q};
    mag    = dig_two ? (m_ext << 1) : m_ext;
    addend = dig_zero ? '0 : (dig_neg ? -mag : mag);
    sum    = a_q + addend;
    shreg  = $signed({sum, q_q, q1_q}) >>> BOOTH_SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = {{XE{signed_mode & multiplier[WIDTH-1]}}, multiplier};
          m_d     = {{XE{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
          q1_d    = 1'b0;
          cnt_d   = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = shreg[WA+WX:WX+1];
        q_d   = shreg[WX:1];
        q1_d  = shreg[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = DONE;
      end
      DONE: begin
        prod_d  = (2*WIDTH)'({a_q, q_q});
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    product = prod_q;
  end

endmodule
